ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port 16K-word data memory (RAM16K). It accepts independent read/write requests from requester A (CPU data port) and requester B (DMA/screen refresh), serialises them onto the memory's `in/load/address/out` port, and returns read data with a one-cycle acknowledge pulse. All memory-side outputs are registered, so the RAM sees stable address, data and load for a full clock cycle.

---
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter and access sequencer for RAM16K
//
// Purpose: serialises read/write requests from requester A (CPU data port) and
// requester B (DMA/screen refresh) onto the single RAM16K port. Every
// transaction takes three cycles: IDLE (grant) -> ACCESS -> ACK.
// Optional feature macro: RAM_ARB_RR_EN (round-robin tie break); without it
// A has fixed priority over B.
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  requester A request fields
//   a_ack, a_rdata          A one-cycle completion pulse and returned data
//   b_*                     same set for requester B
//   ram_in/ram_load/ram_address  registered RAM16K drive
//   ram_out                 RAM16K read data (combinational from address)
//   busy                    high while in ACCESS or ACK
module ram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [13:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [13:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [13:0] ram_address,
    input  logic [15:0] ram_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;
    logic        w_grant_b;

    logic        r_owner_b;
    logic [13:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_load;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [15:0] r_a_rdata;
    logic [15:0] r_b_rdata;

`ifdef RAM_ARB_RR_EN
    // Remembers the last winner; on a tie the other requester is served.
    logic        r_last_b;

    assign w_grant_b = b_req & (~a_req | ~r_last_b);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_b <= 1'b1;
        end else if (w_start) begin
            r_last_b <= w_grant_b;
        end
    end
`else
    // Fixed priority: B is served only when A is not asking.
    assign w_grant_b = b_req & ~a_req;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_ACK;
            S_ACK:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: request fields are latched at the grant edge so the RAM sees
    // stable inputs for the whole ACCESS cycle. ram_out is sampled at the end
    // of ACCESS, i.e. before a write lands, so writes return the old word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner_b <= 1'b0;
            r_addr    <= 14'd0;
            r_wdata   <= 16'd0;
            r_load    <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= 16'd0;
            r_b_rdata <= 16'd0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            if (w_start) begin
                r_owner_b <= w_grant_b;
                r_addr    <= w_grant_b ? b_addr  : a_addr;
                r_wdata   <= w_grant_b ? b_wdata : a_wdata;
                r_load    <= w_grant_b ? b_we    : a_we;
            end
            if (r_state == S_ACCESS) begin
                r_load <= 1'b0;
                if (r_owner_b) begin
                    r_b_rdata <= ram_out;
                    r_b_ack   <= 1'b1;
                end else begin
                    r_a_rdata <= ram_out;
                    r_a_ack   <= 1'b1;
                end
            end
        end
    end

    assign ram_address = r_addr;
    assign ram_in      = r_wdata;
    assign ram_load    = r_load;
    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a RAM16K model
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [13:0] a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [13:0] b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [13:0] ram_address;
    logic [15:0] ram_out;
    logic        busy;

    ram_arbiter dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out), .busy(busy)
    );

    always #5 clock = ~clock;

    // RAM16K model: combinational read, write on rising edge when load.
    logic [15:0] mem [0:16383];
    assign ram_out = mem[ram_address];
    always @(posedge clock) if (ram_load) mem[ram_address] <= ram_in;

    // Reference model: expected memory contents and expected rdata per requester.
    logic [15:0] ref_mem [0:16383];
    logic [15:0] exp_a, exp_b;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          who;      // 0 = A, 1 = B
        bit          we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_a_ack"}, a_ack, 0);
        chk({name, "_b_ack"}, b_ack, 0);
        chk({name, "_a_rdata"}, a_rdata, 0);
        chk({name, "_b_rdata"}, b_rdata, 0);
        chk({name, "_ram_load"}, ram_load, 0);
        chk({name, "_ram_address"}, ram_address, 0);
        chk({name, "_ram_in"}, ram_in, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    // One transaction from an idle arbiter, with cycle-exact checks.
    task automatic txn(input bit who, input bit we, input logic [13:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp);
        @(negedge clock);
        if (!who) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end
        @(negedge clock);                       // ACCESS
        chk("access_busy", busy, 1);
        chk("access_load", ram_load, we);
        chk("access_addr", ram_address, addr);
        if (we) chk("access_wdata", ram_in, wdata);
        chk("access_no_ack", a_ack | b_ack, 0);
        @(negedge clock);                       // ACK
        chk("ack_owner", who ? b_ack : a_ack, 1);
        chk("ack_other", who ? a_ack : b_ack, 0);
        chk("ack_load_low", ram_load, 0);
        chk("ack_addr_held", ram_address, addr);
        if (!who) exp_a = exp; else exp_b = exp;
        chk("ack_a_rdata", a_rdata, exp_a);
        chk("ack_b_rdata", b_rdata, exp_b);
        if (we) ref_mem[addr] = wdata;
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clock);                       // IDLE
        chk("idle_busy", busy, 0);
        chk("idle_no_ack", a_ack | b_ack, 0);
        chk("idle_a_rdata_held", a_rdata, exp_a);
        chk("idle_b_rdata_held", b_rdata, exp_b);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 16'(i) ^ 16'hA5A5;
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        exp_a = '0;
        exp_b = '0;

        tbl[0] = '{0, 1, 14'h0005, 16'h1234, 16'hA5A0};
        tbl[1] = '{0, 0, 14'h0005, 16'h0000, 16'h1234};
        tbl[2] = '{0, 1, 14'h0000, 16'h1111, 16'hA5A5};
        tbl[3] = '{0, 1, 14'h3FFF, 16'h2222, 16'h9A5A};
        tbl[4] = '{0, 0, 14'h0000, 16'h0000, 16'h1111};
        tbl[5] = '{0, 0, 14'h3FFF, 16'h0000, 16'h2222};
        tbl[6] = '{1, 0, 14'h0005, 16'h0000, 16'h1234};
        tbl[7] = '{1, 1, 14'h3FFF, 16'h3333, 16'h2222};
        tbl[8] = '{0, 0, 14'h3FFF, 16'h0000, 16'h3333};

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 14'($urandom); a_wdata = 16'($urandom);
            b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 14'($urandom); b_wdata = 16'($urandom);
            #1 chk_reset_outputs("in_reset");
        end
        @(negedge clock);
        a_req = 1'b0; b_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_reset_outputs("after_reset");
        end

        // Directed table: single write/read, boundary addresses, B path.
        for (int i = 0; i < 9; i++)
            txn(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);

        // Reset during ACCESS aborts a B write of 0xBEEF to 0x3FFF.
        @(negedge clock);
        b_req = 1'b1; b_we = 1'b1; b_addr = 14'h3FFF; b_wdata = 16'hBEEF;
        @(negedge clock);
        chk("abort_load_before", ram_load, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_load_drop", ram_load, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_ack", b_ack, 0);
        @(negedge clock);
        b_req = 1'b0; b_we = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_no_late_ack", b_ack, 0);
        end

        // Contention: both requesters read continuously (last-grant is B after reset).
        ref_mem[14'h0010] = mem[14'h0010];   // untouched words, same as model init
        @(negedge clock);
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0020;
`ifdef RAM_ARB_RR_EN
        for (int i = 1; i <= 11; i++) begin
            logic ea, eb;
            @(negedge clock);
            ea = (i % 6 == 2);
            eb = (i % 6 == 5);
            if (ea) exp_a = ref_mem[14'h0010];
            if (eb) exp_b = ref_mem[14'h0020];
            chk("rr_a_ack", a_ack, ea);
            chk("rr_b_ack", b_ack, eb);
            chk("rr_busy", busy, (i % 3) != 0);
            chk("rr_a_rdata", a_rdata, exp_a);
            chk("rr_b_rdata", b_rdata, exp_b);
            chk("rr_load", ram_load, 0);
            if (i == 11) begin a_req = 1'b0; b_req = 1'b0; end
        end
`else
        for (int i = 1; i <= 14; i++) begin
            logic ea, eb;
            @(negedge clock);
            ea = (i <= 11) && (i % 3 == 2);
            eb = (i == 14);
            if (ea) exp_a = ref_mem[14'h0010];
            if (eb) exp_b = ref_mem[14'h0020];
            chk("fp_a_ack", a_ack, ea);
            chk("fp_b_ack", b_ack, eb);
            chk("fp_busy", busy, (i % 3) != 0);
            chk("fp_a_rdata", a_rdata, exp_a);
            chk("fp_b_rdata", b_rdata, exp_b);
            chk("fp_load", ram_load, 0);
            if (i == 11) a_req = 1'b0;
            if (i == 14) b_req = 1'b0;
        end
`endif
        @(negedge clock);
        chk("contention_idle", busy, 0);

        // The aborted write must not have reached memory.
        txn(0, 0, 14'h3FFF, 16'h0000, 16'h3333);

        // Randomised traffic checked against the reference memory.
        for (int i = 0; i < 150; i++) begin
            bit          who, we;
            logic [13:0] addr;
            logic [15:0] wd;
            who  = 1'($urandom);
            we   = 1'($urandom);
            addr = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 7)) : 14'($urandom);
            wd   = 16'($urandom);
            txn(who, we, addr, wd, ref_mem[addr]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Continuous check: ram_load never outlives a single cycle.
    logic r_prev_load = 1'b0;
    always @(negedge clock) begin
        if (r_prev_load && ram_load) begin
            n_vec++;
            n_bad++;
            $display("FAIL load_width: ram_load high 2 cycles, got 1 expected 0 at %0t", $time);
        end
        r_prev_load <= ram_load;
    end

endmodule
